// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register: valid/ready handshake over a 2-entry skid buffer,
// with synchronous flush/stall and saturating bubble and flushed-entry counters.
module pipe_stage_skid #(
    parameter int WIDTH = 32,
    parameter int NCH   = 2,
    parameter int CNT_W = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 stall_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [NCH*WIDTH-1:0] in_data_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [NCH*WIDTH-1:0] out_data_o,
    output logic [1:0]           occupancy_o,
    output logic [CNT_W-1:0]     bubble_cnt_o,
    output logic [CNT_W-1:0]     flushed_cnt_o
);

    localparam int DW = NCH * WIDTH;

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   main_q, skid_q;
    logic [CNT_W-1:0] bubble_q, flushed_q;
    logic            in_fire, out_fire;
    logic            load_main_in, load_main_skid, load_skid;
    logic [CNT_W:0]  flushed_sum;

    // in_ready_o looks only at local state, never at out_ready_i.
    assign in_ready_o  = rst_i & ~flush_i & ~stall_i & (state_q != FULL);
    assign out_valid_o = ~flush_i & ~stall_i & (state_q != EMPTY);
    assign in_fire     = in_valid_i & in_ready_o;
    assign out_fire    = out_valid_o & out_ready_i;

    assign out_data_o    = main_q;
    assign occupancy_o   = state_q;
    assign bubble_cnt_o  = bubble_q;
    assign flushed_cnt_o = flushed_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= EMPTY;
        end else begin
            // NOTE: sequential state always uses non-blocking assignment so every
            // register samples pre-edge values regardless of block ordering.
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // skipped an assignment would infer a latch.
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d      = ONE;
                        load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (in_fire && !out_fire) begin
                        state_d   = FULL;
                        load_skid = 1'b1;
                    end else if (!in_fire && out_fire) begin
                        state_d = EMPTY;
                    end else if (in_fire && out_fire) begin
                        load_main_in = 1'b1;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_d        = ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        // NOTE: the data registers are reset as well, so out_data_o reads a
        // defined zero after reset instead of stale contents.
        if (!rst_i) begin
            main_q <= '0;
            skid_q <= '0;
        end else if (flush_i) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in) begin
                main_q <= in_data_i;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_data_i;
            end
        end
    end

    // One spare bit catches the carry so the add can saturate.
    assign flushed_sum = {1'b0, flushed_q} + (CNT_W + 1)'(occupancy_o);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bubble_q  <= '0;
            flushed_q <= '0;
        end else begin
            if (out_ready_i && !out_valid_o && (bubble_q != '1)) begin
                bubble_q <= bubble_q + CNT_W'(1);
            end
            if (flush_i) begin
                flushed_q <= flushed_sum[CNT_W] ? '1 : flushed_sum[CNT_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: a per-cycle vector table plus hand-written
// sequences for flush-at-full, counter saturation and asynchronous reset.
module tb_pipe_stage_skid;

    localparam int WIDTH = 32;
    localparam int NCH   = 2;
    localparam int DW    = WIDTH * NCH;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          flush_i, stall_i, in_valid_i, out_ready_i;
    logic [DW-1:0] in_data_i;

    logic          in_ready_o, out_valid_o;
    logic [DW-1:0] out_data_o;
    logic [1:0]    occupancy_o;
    logic [15:0]   bubble_cnt_o, flushed_cnt_o;

    logic          s_in_ready, s_out_valid;
    logic [DW-1:0] s_out_data;
    logic [1:0]    s_occupancy;
    logic [1:0]    s_bubble, s_flushed;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    pipe_stage_skid #(.WIDTH(WIDTH), .NCH(NCH), .CNT_W(16)) u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .stall_i(stall_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
        .occupancy_o(occupancy_o), .bubble_cnt_o(bubble_cnt_o), .flushed_cnt_o(flushed_cnt_o)
    );

    // Narrow-counter copy on the same stimulus, for saturation.
    pipe_stage_skid #(.WIDTH(WIDTH), .NCH(NCH), .CNT_W(2)) u_sat (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .stall_i(stall_i),
        .in_valid_i(in_valid_i), .in_ready_o(s_in_ready), .in_data_i(in_data_i),
        .out_valid_o(s_out_valid), .out_ready_i(out_ready_i), .out_data_o(s_out_data),
        .occupancy_o(s_occupancy), .bubble_cnt_o(s_bubble), .flushed_cnt_o(s_flushed)
    );

    typedef struct {
        logic          flush;
        logic          stall;
        logic          iv;
        logic          ordy;
        logic [DW-1:0] din;
        logic          exp_ir;
        logic          exp_ov;
        logic [DW-1:0] exp_d;
        logic [1:0]    exp_occ;
        int            exp_bub;
        int            exp_fl;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [DW-1:0] d(input logic [31:0] x);
        return {32'hA000_0000 | x, x};
    endfunction

    function automatic int sat3(input int x);
        return (x > 3) ? 3 : x;
    endfunction

    function automatic void add(input logic fl, input logic st, input logic iv, input logic ordy,
                                input logic [DW-1:0] din, input logic ir, input logic ov,
                                input logic [DW-1:0] dq, input logic [1:0] occ,
                                input int bub, input int flc);
        vec_t v;
        v.flush = fl; v.stall = st; v.iv = iv; v.ordy = ordy; v.din = din;
        v.exp_ir = ir; v.exp_ov = ov; v.exp_d = dq; v.exp_occ = occ;
        v.exp_bub = bub; v.exp_fl = flc;
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic st, input logic iv, input logic ordy,
                         input logic [DW-1:0] din);
        flush_i = fl; stall_i = st; in_valid_i = iv; out_ready_i = ordy; in_data_i = din;
    endtask

    initial begin
        //   fl st iv or  din         ir ov exp_d      occ bub fl
        // stream 1,2,3
        add(0, 0, 1, 1, d(1),        1, 0, '0,        0,  0,  0);
        add(0, 0, 1, 1, d(2),        1, 1, d(1),      1,  1,  0);
        add(0, 0, 1, 1, d(3),        1, 1, d(2),      1,  1,  0);
        add(0, 0, 0, 1, '0,          1, 1, d(3),      1,  1,  0);
        // backpressure A5, B6; C7 refused while full
        add(0, 0, 1, 0, d(32'hA5),   1, 0, d(3),      0,  1,  0);
        add(0, 0, 1, 0, d(32'hB6),   1, 1, d(32'hA5), 1,  1,  0);
        add(0, 0, 1, 0, d(32'hC7),   0, 1, d(32'hA5), 2,  1,  0);
        add(0, 0, 0, 1, '0,          0, 1, d(32'hA5), 2,  1,  0);
        add(0, 0, 0, 1, '0,          1, 1, d(32'hB6), 1,  1,  0);
        add(0, 0, 0, 0, '0,          1, 0, d(32'hB6), 0,  1,  0);
        // flush at FULL
        add(0, 0, 1, 0, d(32'h11),   1, 0, d(32'hB6), 0,  1,  0);
        add(0, 0, 1, 0, d(32'h22),   1, 1, d(32'h11), 1,  1,  0);
        add(1, 0, 1, 1, d(32'h33),   0, 0, d(32'h11), 2,  1,  0);
        add(0, 0, 0, 0, '0,          1, 0, '0,        0,  2,  2);
        // stall holds 0x55 for three cycles
        add(0, 0, 1, 0, d(32'h55),   1, 0, '0,        0,  2,  2);
        add(0, 1, 1, 1, d(32'h66),   0, 0, d(32'h55), 1,  2,  2);
        add(0, 1, 1, 1, d(32'h66),   0, 0, d(32'h55), 1,  3,  2);
        add(0, 1, 1, 1, d(32'h66),   0, 0, d(32'h55), 1,  4,  2);
        add(0, 0, 0, 0, '0,          1, 1, d(32'h55), 1,  5,  2);
        // flush and stall together: flush wins
        add(1, 1, 1, 0, d(32'h77),   0, 0, d(32'h55), 1,  5,  2);
        add(0, 0, 0, 0, '0,          1, 0, '0,        0,  5,  3);

        rst_i = 1'b0;
        drive(0, 0, 1, 1, d(32'hEE));
        #3;
        check("rst_in_ready", 64'(in_ready_o), 64'd0);
        check("rst_out_valid", 64'(out_valid_o), 64'd0);
        check("rst_occupancy", 64'(occupancy_o), 64'd0);
        check("rst_out_data", out_data_o, 64'd0);
        repeat (2) @(negedge clk_i);
        check("rst_bubble", 64'(bubble_cnt_o), 64'd0);
        drive(0, 0, 0, 0, '0);
        @(negedge clk_i);
        rst_i = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk_i);
            drive(tbl[i].flush, tbl[i].stall, tbl[i].iv, tbl[i].ordy, tbl[i].din);
            #1;
            check($sformatf("v%0d_in_ready", i), 64'(in_ready_o), 64'(tbl[i].exp_ir));
            check($sformatf("v%0d_out_valid", i), 64'(out_valid_o), 64'(tbl[i].exp_ov));
            check($sformatf("v%0d_out_data", i), out_data_o, tbl[i].exp_d);
            check($sformatf("v%0d_occupancy", i), 64'(occupancy_o), 64'(tbl[i].exp_occ));
            check($sformatf("v%0d_bubble", i), 64'(bubble_cnt_o), 64'(tbl[i].exp_bub));
            check($sformatf("v%0d_flushed", i), 64'(flushed_cnt_o), 64'(tbl[i].exp_fl));
            check($sformatf("v%0d_sat_bubble", i), 64'(s_bubble), 64'(sat3(tbl[i].exp_bub)));
            check($sformatf("v%0d_sat_flushed", i), 64'(s_flushed), 64'(sat3(tbl[i].exp_fl)));
        end

        // Fill to FULL and flush again: narrow counter must stay pinned at 3.
        @(negedge clk_i); drive(0, 0, 1, 0, d(32'h77));
        @(negedge clk_i); drive(0, 0, 1, 0, d(32'h88));
        @(negedge clk_i); drive(0, 0, 0, 0, '0);
        #1;
        check("fill_occupancy", 64'(occupancy_o), 64'd2);
        check("fill_out_data", out_data_o, d(32'h77));
        check("fill_in_ready", 64'(in_ready_o), 64'd0);
        drive(1, 0, 0, 0, '0);
        @(negedge clk_i); drive(0, 0, 0, 0, '0);
        #1;
        check("flush2_occupancy", 64'(occupancy_o), 64'd0);
        check("flush2_flushed", 64'(flushed_cnt_o), 64'd5);
        check("flush2_sat_flushed", 64'(s_flushed), 64'd3);
        check("flush2_sat_bubble", 64'(s_bubble), 64'd3);

        // Refill to FULL, then assert reset between clock edges.
        @(negedge clk_i); drive(0, 0, 1, 0, d(32'h99));
        @(negedge clk_i); drive(0, 0, 1, 0, d(32'hAA));
        @(negedge clk_i); drive(0, 0, 0, 1, '0);
        #1;
        check("refill_occupancy", 64'(occupancy_o), 64'd2);
        @(posedge clk_i);
        #2;
        rst_i = 1'b0;
        #1;
        check("async_rst_out_valid", 64'(out_valid_o), 64'd0);
        check("async_rst_in_ready", 64'(in_ready_o), 64'd0);
        check("async_rst_occupancy", 64'(occupancy_o), 64'd0);
        check("async_rst_out_data", out_data_o, 64'd0);
        check("async_rst_bubble", 64'(bubble_cnt_o), 64'd0);
        check("async_rst_flushed", 64'(flushed_cnt_o), 64'd0);

        // Recovery after reset: one entry through with one cycle of latency.
        @(negedge clk_i);
        rst_i = 1'b1;
        drive(0, 0, 1, 1, d(32'h123));
        #1;
        check("post_rst_in_ready", 64'(in_ready_o), 64'd1);
        @(negedge clk_i); drive(0, 0, 0, 1, '0);
        #1;
        check("post_rst_out_valid", 64'(out_valid_o), 64'd1);
        check("post_rst_out_data", out_data_o, d(32'h123));
        check("post_rst_flushed", 64'(flushed_cnt_o), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
